// File: rtl/balance_disp_pkg.sv
// rtl/balance_disp_pkg.sv - shared state encoding, segment patterns and limits for the balance display
package balance_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Active-high masks, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic int max_val(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD nibble to active-high 7-segment mask
module seg7_decode
   import balance_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/balance_bcd_encoder.sv
// rtl/balance_bcd_encoder.sv - iterative double-dabble of the account balance into four committed display digits
module balance_bcd_encoder
   import balance_disp_pkg::*;
#(
   parameter int IN_W   = 27,
   parameter int DIGITS = 4
)(
   input  logic            dclk,
   input  logic            clr,
   input  logic [IN_W-1:0] balance,
   output logic [3:0]      digit3,
   output logic [3:0]      digit2,
   output logic [3:0]      digit1,
   output logic [3:0]      digit0,
   output logic [6:0]      seg3,
   output logic [6:0]      seg2,
   output logic [6:0]      seg1,
   output logic [6:0]      seg0,
   output logic            ovf,
   output logic            done,
   output logic            busy
);

   localparam int              BCD_W = DIGITS * 4;
   localparam int              CNT_W = $clog2(IN_W);
   localparam logic [IN_W-1:0] MAX   = IN_W'(max_val(DIGITS));
   localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

   state_t            state;
   logic              pending;
   logic              ovf_c;
   logic [IN_W-1:0]   last_bal;
   logic [IN_W-1:0]   bin;
   logic [BCD_W-1:0]  bcd;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        digit [DIGITS];
   logic [6:0]        seg   [DIGITS];

   // Clamping to MAX keeps the running BCD value below 10^DIGITS, so no carry-out nibble is needed
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge dclk) begin
      if (clr) begin
         state    <= IDLE;
         pending  <= 1'b1;
         ovf_c    <= 1'b0;
         last_bal <= '0;
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            digit[i] <= 4'd0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pending || (balance != last_bal)) begin
                  last_bal <= balance;
                  ovf_c    <= (balance > MAX);
                  bin      <= (balance > MAX) ? MAX : balance;
                  bcd      <= '0;
                  cnt      <= '0;
                  pending  <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               for (int i = 0; i < DIGITS; i++) begin
                  digit[i] <= bcd[i*4 +: 4];
               end
               ovf   <= ovf_c;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Decoding the committed digits keeps segment masks in lockstep with them
   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .bcd (digit[g]),
         .seg (seg[g])
      );
   end

   assign digit3 = digit[3];
   assign digit2 = digit[2];
   assign digit1 = digit[1];
   assign digit0 = digit[0];
   assign seg3   = seg[3];
   assign seg2   = seg[2];
   assign seg1   = seg[1];
   assign seg0   = seg[0];

endmodule

// File: tb/tb_balance_bcd_encoder.sv
// tb/tb_balance_bcd_encoder.sv - scoreboard bench for the balance BCD encoder
module tb_balance_bcd_encoder;

   logic        dclk = 1'b0;
   logic        clr = 1'b1;
   logic [26:0] balance = '0;
   logic [3:0]  digit3, digit2, digit1, digit0;
   logic [6:0]  seg3, seg2, seg1, seg0;
   logic        ovf, done, busy;

   localparam logic [6:0] S0 = 7'b0111111;
   localparam logic [6:0] S1 = 7'b0000110;
   localparam logic [6:0] S2 = 7'b1011011;
   localparam logic [6:0] S3 = 7'b1001111;
   localparam logic [6:0] S4 = 7'b1100110;
   localparam logic [6:0] S5 = 7'b1101101;
   localparam logic [6:0] S7 = 7'b0000111;
   localparam logic [6:0] S9 = 7'b1101111;

   typedef struct {
      logic [15:0] dig;
      logic [27:0] seg;
      logic        ovf;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   int   ncommit = 0;
   int   target = 0;
   logic prev_done = 1'b0;

   balance_bcd_encoder #(.IN_W(27), .DIGITS(4)) dut (
      .dclk    (dclk),
      .clr     (clr),
      .balance (balance),
      .digit3  (digit3),
      .digit2  (digit2),
      .digit1  (digit1),
      .digit0  (digit0),
      .seg3    (seg3),
      .seg2    (seg2),
      .seg1    (seg1),
      .seg0    (seg0),
      .ovf     (ovf),
      .done    (done),
      .busy    (busy)
   );

   always #20 dclk = ~dclk;

   always @(posedge dclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [15:0] dig, input logic [27:0] seg, input logic o, input int at);
      exp_t e;
      e.dig = dig;
      e.seg = seg;
      e.ovf = o;
      e.at  = at;
      sb.push_back(e);
      target++;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && ncommit < target; i++) @(negedge dclk);
      if (ncommit < target) check("done_timeout", 32'(ncommit), 32'(target));
   endtask

   task automatic apply(input logic [26:0] bal, input logic [15:0] dig, input logic [27:0] seg, input logic o);
      balance = bal;
      push(dig, seg, o, cyc + 1 + 28);
      wait_done();
   endtask

   task automatic check_reset_vals();
      check("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
      check("rst_segs", 32'({seg3, seg2, seg1, seg0}), 32'({S0, S0, S0, S0}));
      check("rst_ovf", 32'(ovf), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
   endtask

   always @(negedge dclk) begin
      if (prev_done) check("done_pulse_width", 32'(done), 32'h0);
      prev_done = done;
      if (!clr && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e.dig));
            check("segs", 32'({seg3, seg2, seg1, seg0}), 32'(e.seg));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("done_cycle", 32'(cyc), 32'(e.at));
         end
         ncommit++;
      end
   end

   initial begin
      repeat (3) @(negedge dclk);
      check_reset_vals();

      clr = 1'b0;
      push(16'h0000, {S0, S0, S0, S0}, 1'b0, cyc + 1 + 28);
      wait_done();

      apply(27'd1234,  16'h1234, {S1, S2, S3, S4}, 1'b0);
      apply(27'd9999,  16'h9999, {S9, S9, S9, S9}, 1'b0);
      apply(27'd10000, 16'h9999, {S9, S9, S9, S9}, 1'b1);
      apply(27'h7FFFFFF, 16'h9999, {S9, S9, S9, S9}, 1'b1);

      begin
         int at0;
         balance = 27'd500;
         at0 = cyc + 1;
         push(16'h0500, {S0, S5, S0, S0}, 1'b0, at0 + 28);
         repeat (10) @(negedge dclk);
         check("busy_in_shift", 32'(busy), 32'h1);
         balance = 27'd750;
         push(16'h0750, {S0, S7, S5, S0}, 1'b0, at0 + 28 + 29);
         wait_done();
      end

      balance = 27'd4321;
      repeat (5) @(negedge dclk);
      check("busy_before_clr", 32'(busy), 32'h1);
      clr = 1'b1;
      @(negedge dclk);
      check_reset_vals();
      clr = 1'b0;
      push(16'h4321, {S4, S3, S2, S1}, 1'b0, cyc + 1 + 28);
      wait_done();

      repeat (40) @(negedge dclk);
      check("idle_no_pending", 32'(sb.size()), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/balance_bcd_encoder.md
# balance_bcd_encoder

Sequential binary-to-display encoder sitting directly upstream of the 640x480 VGA balance renderer. It takes the 27-bit account balance and converts it to four decimal digits with an iterative double-dabble, one bit per clock. It publishes the digits and active-high 7-segment masks that the renderer maps onto its per-segment enable bits. Outputs are double-buffered, so the renderer never sees a partially converted value.

## Interface
- IN_W, 27, balance width in bits
- DIGITS, 4, decimal digits produced (digit 3 = thousands, leftmost on screen)
- dclk  in  1  pixel clock (25 MHz); all logic on rising edge
- clr  in  1  synchronous active-high reset (one clock, synchronous; active-high)
- balance  in  IN_W  unsigned binary balance; may change at any time
- digit3..digit0  out  4 each  committed BCD digits
- seg3..seg0  out  7 each  committed segment masks, active-high, bit order {g,f,e,d,c,b,a}
- ovf  out  1  committed balance exceeded 10^DIGITS-1; display saturated
- done  out  1  one-cycle pulse when new outputs commit
- busy  out  1  high in SHIFT and COMMIT

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- Reset (clr=1 at an edge):
  - State becomes IDLE.
  - All digits become 0; all seg outputs become 7'b0111111 ('0').
  - ovf=0, done=0, busy=0.
  - pending flag set to 1, so the first conversion starts on the first non-reset edge.
- IDLE:
  - Capture condition: pending=1 or balance != last_bal.
  - On capture:
    - last_bal<=balance.
    - ovf_c<=(balance>MAX), where MAX=10^DIGITS-1.
    - bin<=min(balance,MAX).
    - bcd<=0, cnt<=0, pending<=0.
    - Go to SHIFT.
  - Otherwise hold.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd,bin} shifts left by 1.
  - cnt increments.
  - The edge with cnt==IN_W-1 goes to COMMIT.
- COMMIT, one edge:
  - digitN<=bcd nibble N; segN<=decode(nibble N).
  - ovf<=ovf_c, done<=1.
  - Go to IDLE.
  - done is cleared on the following edge.
- Width rules:
  - bcd register is DIGITS*4 bits.
  - The clamp guarantees no BCD carry-out, so no wider accumulator is needed.
- Segment map (renderer positions):
  - a = top middle, b = top right, c = bottom right, d = bottom middle, e = bottom left, f = top left, g = middle.
  - Codes 0-9 use standard patterns. Nibbles >9 cannot occur; decode them to 7'b0000000.
- Balance changes during SHIFT/COMMIT:
  - The in-flight conversion completes with its captured value.
  - The change is detected in the next IDLE cycle via last_bal and converted then.
  - Intermediate values may be skipped; the final stable value is always displayed.
- Reset mid-conversion:
  - Conversion is abandoned and outputs go to reset values the same edge.
  - Conversion of the current balance restarts after reset deasserts.

## Timing
- Capture edge E0 (IDLE→SHIFT).
- Shift edges E1..E(IN_W); the last one enters COMMIT.
- Outputs and done update at edge E(IN_W+1) = E28 with defaults.
- Latency: IN_W+1 edges from capture to new outputs.
- Back-to-back conversions: IN_W+2 cycles per conversion (one IDLE cycle between).
- Outputs are fully registered and stable between commits.

## Structure
- Package balance_disp_pkg holds:
  - state enum {IDLE, SHIFT, COMMIT}
  - SEG_0..SEG_9 constants and SEG_BLANK
  - function max_val(DIGITS)
- Sub-module seg7_decode: combinational 4-bit BCD → 7-bit active-high mask, instantiated DIGITS times on the committed digits.
- Double-dabble datapath and FSM live in the top.

## Test plan
- Reset release with balance=0 → done after 28 cycles; digits 0,0,0,0; all seg=0111111; ovf=0.
- balance=1234 → digits 1,2,3,4.
  - seg3=0000110, seg2=1011011, seg1=1001111, seg0=1100110.
  - done exactly 28 edges after capture.
- balance=9999 → digits 9,9,9,9, ovf=0. Then balance=10000 → digits 9,9,9,9, ovf=1.
- balance=2^27-1 → digits 9,9,9,9, ovf=1.
- balance 500→750 at cycle 10 of conversion → first done shows 0500; second done shows 0750 exactly 29 edges after the first.
- clr asserted mid-SHIFT with 4321 pending:
  - Outputs go to reset values the same edge; busy=0.
  - After release, 4321 appears 28 edges later with no stale partial value.
